// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI slave endpoint: oversampled SCK/SS/MOSI, word deserialiser, single-entry tx buffer
module spi_slave #(
    parameter int   DATA_BITS   = 8,
    parameter logic CPOL        = 1'b0,
    parameter logic CPHA        = 1'b1,
    parameter logic LSBF        = 1'b0,
    parameter int   SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 SCK,
    input  logic                 SS,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic                 miso_oe,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 load_in,
    output logic                 ready_out,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    output logic                 busy_out
);
    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
    logic                   sck_prev, ss_prev;
    logic                   sample_q, shift_q, ss_fall_q, ss_rise_q, mosi_q;
    logic [CW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   rx_sr, tx_sr, buf_data;
    logic                   buf_full;
    logic                   start, stop, do_sample, last, do_shift, consume;
    logic [DATA_BITS-1:0]   rx_next, tx_load, tx_shifted;

    function automatic logic out_bit(input logic [DATA_BITS-1:0] v);
        return LSBF ? v[0] : v[DATA_BITS-1];
    endfunction

    wire sck_s  = sck_sync[SYNC_STAGES-1];
    wire ss_s   = ss_sync[SYNC_STAGES-1];
    wire lead   = (sck_prev == CPOL) && (sck_s != CPOL);
    wire trail  = (sck_prev != CPOL) && (sck_s == CPOL);

    // Edge strobes are registered once more so every action lands a fixed SYNC_STAGES+2 cycles after the pin edge
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sck_sync  <= {SYNC_STAGES{CPOL}};
            ss_sync   <= '1;
            mosi_sync <= '0;
            sck_prev  <= CPOL;
            ss_prev   <= 1'b1;
            sample_q  <= 1'b0;
            shift_q   <= 1'b0;
            ss_fall_q <= 1'b0;
            ss_rise_q <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sck_prev  <= sck_s;
            ss_prev   <= ss_s;
            sample_q  <= CPHA ? trail : lead;
            shift_q   <= CPHA ? lead : trail;
            ss_fall_q <= ss_prev & ~ss_s;
            ss_rise_q <= ~ss_prev & ss_s;
            mosi_q    <= mosi_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        stop       = 1'b0;
        do_sample  = 1'b0;
        do_shift   = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall_q) begin
                    state_next = ACTIVE;
                    start      = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise_q) begin
                    state_next = IDLE;
                    stop       = 1'b1;
                end else begin
                    do_sample = sample_q;
                    do_shift  = shift_q && (bit_cnt != '0);
                end
            end
            default: state_next = IDLE;
        endcase
        last    = do_sample && (bit_cnt == LAST_BIT);
        consume = start || last;
    end

    assign rx_next    = LSBF ? {mosi_q, rx_sr[DATA_BITS-1:1]} : {rx_sr[DATA_BITS-2:0], mosi_q};
    assign tx_load    = buf_full ? buf_data : '0;
    assign tx_shifted = LSBF ? (tx_sr >> 1) : (tx_sr << 1);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_cnt   <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            MISO      <= 1'b0;
            miso_oe   <= 1'b0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            if (start) begin
                bit_cnt <= '0;
                rx_sr   <= '0;
                tx_sr   <= tx_load;
                MISO    <= out_bit(tx_load);
                miso_oe <= 1'b1;
            end else if (stop) begin
                bit_cnt <= '0;
                MISO    <= 1'b0;
                miso_oe <= 1'b0;
            end else if (last) begin
                bit_cnt   <= '0;
                rx_sr     <= rx_next;
                data_out  <= rx_next;
                valid_out <= 1'b1;
                tx_sr     <= tx_load;
                MISO      <= out_bit(tx_load);
            end else if (do_sample) begin
                bit_cnt <= bit_cnt + 1'b1;
                rx_sr   <= rx_next;
            end else if (do_shift) begin
                tx_sr <= tx_shifted;
                MISO  <= out_bit(tx_shifted);
            end
        end
    end

    // A load arriving while an empty buffer is consumed is kept for the following word
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            buf_data <= '0;
            buf_full <= 1'b0;
        end else if (load_in && !buf_full) begin
            buf_data <= data_in;
            buf_full <= 1'b1;
        end else if (consume) begin
            buf_full <= 1'b0;
        end
    end

    assign ready_out = ~buf_full;
    assign busy_out  = (state == ACTIVE);
endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - self-checking bench for spi_slave across all CPOL/CPHA/LSBF modes
module tb_spi_slave;
    localparam int NM   = 8;
    localparam int HALF = 6;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    logic       sck[NM], ss[NM], mosi[NM], load[NM];
    logic       miso[NM], oe[NM], rdy[NM], vld[NM], busy[NM], vld_prev[NM];
    logic [7:0] din[NM], dout[NM];
    int         vld_cnt[NM] = '{default: 0};
    int         long_cnt = 0;
    int         tests = 0;
    int         fails = 0;

    genvar g;
    generate
        for (g = 0; g < NM; g++) begin : gen_dut
            spi_slave #(
                .DATA_BITS(8), .CPOL(1'((g / 4) % 2)), .CPHA(1'((g / 2) % 2)),
                .LSBF(1'(g % 2)), .SYNC_STAGES(2)
            ) dut (
                .clk(clk), .n_rst(n_rst), .SCK(sck[g]), .SS(ss[g]), .MOSI(mosi[g]),
                .MISO(miso[g]), .miso_oe(oe[g]), .data_in(din[g]), .load_in(load[g]),
                .ready_out(rdy[g]), .data_out(dout[g]), .valid_out(vld[g]), .busy_out(busy[g])
            );
        end
    endgenerate

    always @(posedge clk) begin
        for (int i = 0; i < NM; i++) begin
            if (vld[i] === 1'b1) vld_cnt[i] <= vld_cnt[i] + 1;
            if (vld[i] === 1'b1 && vld_prev[i] === 1'b1) long_cnt <= long_cnt + 1;
            vld_prev[i] <= vld[i];
        end
    end

    function automatic logic cpol_of(input int m); return 1'((m / 4) % 2); endfunction
    function automatic logic cpha_of(input int m); return 1'((m / 2) % 2); endfunction
    function automatic logic lsbf_of(input int m); return 1'(m % 2); endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_word(input int m, input logic [7:0] v);
        din[m]  = v;
        load[m] = 1'b1;
        tick(1);
        load[m] = 1'b0;
    endtask

    task automatic wait_rdy(input int m);
        int n = 0;
        while (rdy[m] !== 1'b1 && n < 300) begin
            tick(1);
            n++;
        end
        chk("rdy_wait", {31'd0, rdy[m]}, 32'd1);
    endtask

    // Behavioural SPI master: the bit order and edge roles come straight from the mode definition
    task automatic xfer(input int m, input logic [7:0] tx, input int nbits,
                        input bit keep_ss, input bit do_select, output logic [7:0] rx);
        logic pol, pha;
        int   b;
        pol = cpol_of(m);
        pha = cpha_of(m);
        rx  = 8'h00;
        if (do_select) begin
            ss[m] = 1'b0;
            tick(HALF);
        end
        for (int i = 0; i < nbits; i++) begin
            b = lsbf_of(m) ? i : 7 - i;
            if (!pha) begin
                mosi[m] = tx[b];
                tick(1);
                sck[m] = ~pol;
                rx[b]  = miso[m];
                tick(HALF);
                sck[m] = pol;
                tick(HALF - 1);
            end else begin
                sck[m]  = ~pol;
                mosi[m] = tx[b];
                tick(HALF);
                sck[m] = pol;
                rx[b]  = miso[m];
                tick(HALF);
            end
        end
        if (!keep_ss) begin
            ss[m] = 1'b1;
            tick(HALF);
        end
    endtask

    task automatic chk_reset_outputs(input string tag, input int m);
        chk({tag, "_miso"},  {31'd0, miso[m]}, 32'd0);
        chk({tag, "_oe"},    {31'd0, oe[m]},   32'd0);
        chk({tag, "_dout"},  {24'd0, dout[m]}, 32'd0);
        chk({tag, "_valid"}, {31'd0, vld[m]},  32'd0);
        chk({tag, "_ready"}, {31'd0, rdy[m]},  32'd1);
        chk({tag, "_busy"},  {31'd0, busy[m]}, 32'd0);
    endtask

    typedef struct {
        int         mode;
        logic [7:0] mtx;
        logic [7:0] stx;
        bit         loaded;
    } vec_t;

    vec_t       vecs[24];
    logic [7:0] r, r0, r1, r2, prev, exp_m;
    int         v0;
    int         m;

    initial begin
        for (int i = 0; i < NM; i++) begin
            sck[i] = cpol_of(i); ss[i] = 1'b1; mosi[i] = 1'b0; load[i] = 1'b0; din[i] = 8'h00;
        end
        for (int i = 0; i < 24; i++) begin
            if (i < 8) vecs[i] = '{mode: i, mtx: 8'hC3, stx: 8'h96, loaded: 1'b1};
            else vecs[i] = '{mode: int'($urandom_range(0, 7)), mtx: 8'($urandom), stx: 8'($urandom),
                             loaded: ($urandom_range(0, 3) != 0)};
        end
        tick(3);
        chk_reset_outputs("por", 2);
        n_rst = 1'b1;
        tick(2);

        m = 2;
        load_word(m, 8'hA5);
        chk("basic_rdy_low", {31'd0, rdy[m]}, 32'd0);
        v0 = vld_cnt[m];
        xfer(m, 8'h3C, 8, 0, 1, r);
        chk("basic_dout", {24'd0, dout[m]}, 32'h3C);
        chk("basic_vcount", vld_cnt[m] - v0, 32'd1);
        chk("basic_mrx", {24'd0, r}, 32'hA5);
        chk("basic_rdy", {31'd0, rdy[m]}, 32'd1);

        load_word(m, 8'h11);
        v0 = vld_cnt[m];
        fork
            begin
                xfer(m, 8'h01, 8, 1, 1, r0);
                chk("b2b_dout0", {24'd0, dout[m]}, 32'h01);
                xfer(m, 8'h80, 8, 1, 0, r1);
                chk("b2b_dout1", {24'd0, dout[m]}, 32'h80);
                xfer(m, 8'hFF, 8, 0, 0, r2);
                chk("b2b_dout2", {24'd0, dout[m]}, 32'hFF);
            end
            begin
                wait_rdy(m);
                load_word(m, 8'h22);
                wait_rdy(m);
                load_word(m, 8'h33);
            end
        join
        chk("b2b_vcount", vld_cnt[m] - v0, 32'd3);
        chk("b2b_mrx0", {24'd0, r0}, 32'h11);
        chk("b2b_mrx1", {24'd0, r1}, 32'h22);
        chk("b2b_mrx2", {24'd0, r2}, 32'h33);

        xfer(m, 8'h77, 8, 0, 1, r);
        chk("underrun_mrx", {24'd0, r}, 32'h00);
        chk("underrun_dout", {24'd0, dout[m]}, 32'h77);

        prev = dout[m];
        load_word(m, 8'h42);
        v0 = vld_cnt[m];
        xfer(m, 8'hE1, 4, 0, 1, r);
        chk("abort_vcount", vld_cnt[m] - v0, 32'd0);
        chk("abort_dout", {24'd0, dout[m]}, {24'd0, prev});
        chk("abort_oe", {31'd0, oe[m]}, 32'd0);
        chk("abort_busy", {31'd0, busy[m]}, 32'd0);
        xfer(m, 8'h5A, 8, 0, 1, r);
        chk("post_abort_dout", {24'd0, dout[m]}, 32'h5A);
        chk("post_abort_mrx", {24'd0, r}, 32'h00);

        for (int k = 0; k < 24; k++) begin
            m = vecs[k].mode;
            if (vecs[k].loaded) load_word(m, vecs[k].stx);
            exp_m = vecs[k].loaded ? vecs[k].stx : 8'h00;
            v0 = vld_cnt[m];
            xfer(m, vecs[k].mtx, 8, 0, 1, r);
            chk($sformatf("vec%0d_m%0d_dout", k, m), {24'd0, dout[m]}, {24'd0, vecs[k].mtx});
            chk($sformatf("vec%0d_m%0d_vcount", k, m), vld_cnt[m] - v0, 32'd1);
            chk($sformatf("vec%0d_m%0d_mrx", k, m), {24'd0, r}, {24'd0, exp_m});
        end

        m = 2;
        load_word(m, 8'h33);
        xfer(m, 8'hF0, 4, 1, 1, r);
        chk("midrst_busy_before", {31'd0, busy[m]}, 32'd1);
        n_rst = 1'b0;
        #1;
        chk_reset_outputs("midrst", m);
        ss[m] = 1'b1;
        tick(3);
        n_rst = 1'b1;
        tick(2);
        load_word(m, 8'hAB);
        load_word(m, 8'hCD);
        chk("ign_rdy_low", {31'd0, rdy[m]}, 32'd0);
        xfer(m, 8'h5C, 8, 0, 1, r);
        chk("ign_mrx", {24'd0, r}, 32'hAB);
        chk("ign_dout", {24'd0, dout[m]}, 32'h5C);
        load_word(m, 8'h12);
        xfer(m, 8'h9E, 8, 0, 1, r);
        chk("final_mrx", {24'd0, r}, 32'h12);
        chk("final_dout", {24'd0, dout[m]}, 32'h9E);

        chk("valid_width", long_cnt, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI slave endpoint that sits on the far side of the bus from the team's SPI master and consumes its SCK/SS/MOSI. It oversamples the bus in the local clk domain, deserialises MOSI into words and serialises a host-supplied word onto MISO. It uses the same CPOL/CPHA/LSBF conventions as the master, so the pair can be tested back-to-back and used for board-to-board links.

Parameters:
DATA_BITS, 8, word length in bits (≥2)
CPOL, 0, SCK idle level
CPHA, 1, 0 = sample on leading edge; 1 = sample on trailing edge
LSBF, 0, 0 = MSB first; 1 = LSB first
SYNC_STAGES, 2, synchroniser depth for SCK/SS/MOSI (≥2)

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
SCK  in  1  serial clock from master (asynchronous)
SS  in  1  slave select, active low (asynchronous)
MOSI  in  1  serial data from master (asynchronous)
MISO  out  1  serial data to master
miso_oe  out  1  MISO output enable (high while selected)
data_in  in  DATA_BITS  next word to transmit
load_in  in  1  host strobe: write data_in into tx buffer
ready_out  out  1  tx buffer empty, load_in accepted
data_out  out  DATA_BITS  last received word
valid_out  out  1  one-cycle pulse, data_out updated
busy_out  out  1  slave selected (state ACTIVE)

Behaviour:
- Reset is asserted by n_rst low, asynchronously; the block runs on clk.
- Reset values:
  - MISO=0, miso_oe=0, data_out=0, valid_out=0, ready_out=1, busy_out=0.
  - Synchronisers: SCK chain=CPOL, SS chain=1, MOSI chain=0.
  - bit_cnt=0, state=IDLE, tx buffer empty.
- All edge detection uses the synchronised signals only:
  - lead edge: sync SCK leaves CPOL; trail edge: sync SCK returns to CPOL.
  - sample edge = lead if CPHA=0, else trail; shift edge = the other one.
- State machine has two states, IDLE and ACTIVE.
- IDLE -> ACTIVE on sync SS falling edge:
  - bit_cnt=0, rx shift reg cleared, miso_oe=1.
  - tx shift reg loaded from tx buffer if full (buffer emptied, ready_out=1 next cycle), otherwise all zeros.
  - MISO = tx[DATA_BITS-1] (LSBF=0) or tx[0] (LSBF=1). The first bit is therefore valid before the first SCK edge for either CPHA.
- ACTIVE, sample edge:
  - Shift MOSI into rx: left shift if LSBF=0, right shift if LSBF=1.
  - bit_cnt increments.
  - On the DATA_BITS-th sample:
    - data_out = complete word including that bit; valid_out=1 for exactly the next cycle; bit_cnt=0.
    - tx reloaded from tx buffer (or zeros if empty), same rule as SS fall.
- ACTIVE, shift edge: tx shifts by one toward the output bit only when bit_cnt≠0. The first shift edge of each word is ignored so the preloaded bit is held.
- ACTIVE -> IDLE on sync SS rising edge, at any bit position:
  - A partial word is discarded: no valid_out, data_out unchanged, bit_cnt=0.
  - miso_oe=0, MISO=0.
  - The tx word already loaded into the shift reg is lost; the buffer is not refilled.
- SCK edges while IDLE are ignored.
- busy_out = (state==ACTIVE).
- Tx buffer is a single register:
  - load_in && ready_out: capture data_in, ready_out=0 next cycle.
  - load_in && !ready_out: ignored, no change.
  - load_in in the same cycle as a buffer consumption with the buffer empty: zeros are sent for the current word and data_in is captured for the following word.
- Latency:
  - valid_out rises SYNC_STAGES+2 clk cycles after the raw final sample edge.
  - MISO updates SYNC_STAGES+2 clk cycles after the raw shift edge.
- Timing requirement: SCK half-period ≥ SYNC_STAGES+3 clk cycles. With the team master on the same clk this means BRDV ≥ 2*(SYNC_STAGES+3); use BRDV=12 for SYNC_STAGES=2.
- Reset mid-transfer returns all state to reset values immediately; the next SS fall starts a clean word.

Test Plan:
- Basic (CPOL=0, CPHA=1, LSBF=0, team master BRDV=12): load 0xA5, master sends 0x3C -> slave valid_out one pulse with data_out=0x3C; master data_out=0xA5; ready_out=1 after SS fall.
- Back-to-back: master tied_SS=1, data_words=3, sends 0x01, 0x80, 0xFF; host reloads after each ready_out with 0x11, 0x22, 0x33 -> three valid_out pulses with 0x01/0x80/0xFF; master receives 0x11/0x22/0x33.
- Underrun: no load before the second word -> slave transmits 0x00 for it; its rx word is still received correctly.
- Abort: SS raised after 4 SCK cycles -> no valid_out, data_out keeps its previous value, miso_oe=0; the next full transfer of 0x5A -> data_out=0x5A.
- Mode sweep: all CPOL/CPHA combinations × LSBF=0/1 with master 0xC3, slave 0x96 -> both sides exact in every mode.
- Reset: n_rst pulsed low mid-word -> outputs return to reset values the same cycle; load_in ignored while ready_out=0; the following transfer is correct.
